aes_256_stream_ctrl: RTL and testbench

AES_256_STREAM_CTRL -- requirements
Module: aes_256_stream_ctrl

---
 rtl/aes_256_stream_ctrl_pkg.sv | 16 +
 rtl/aes_256_stream_ctrl_if.sv | 32 +++
 rtl/aes_256_out_fifo.sv | 51 +++++
 rtl/aes_256_stream_ctrl.sv | 105 ++++++++++
 tb/tb_aes_256_stream_ctrl.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_256_stream_ctrl_pkg.sv
// Shared types and widths for the AES-256 stream controller.
// Imported by the controller, its output FIFO and the stream interface.
package aes_256_stream_ctrl_pkg;

  localparam int BLOCK_W     = 128;
  localparam int KEY_W       = 256;
  localparam int DEF_LATENCY = 15;

  typedef enum logic [1:0] {
    NOKEY,
    SETTLE,
    RUN,
    DRAIN
  } ctrl_state_t;

endpackage

// File: rtl/aes_256_stream_ctrl_if.sv
// Key, plaintext and ciphertext handshakes of the stream controller.
// The slave side is the controller, the master side is its user.
interface aes_256_stream_ctrl_if;
  import aes_256_stream_ctrl_pkg::*;

  logic               key_valid;
  logic [KEY_W-1:0]   key_in;
  logic               key_ready;
  logic               in_valid;
  logic [BLOCK_W-1:0] in_data;
  logic               in_ready;
  logic               out_valid;
  logic [BLOCK_W-1:0] out_data;
  logic               out_ready;

  modport master (
    output key_valid, key_in,
    output in_valid, in_data,
    output out_ready,
    input  key_ready, in_ready,
    input  out_valid, out_data
  );

  modport slave (
    input  key_valid, key_in,
    input  in_valid, in_data,
    input  out_ready,
    output key_ready, in_ready,
    output out_valid, out_data
  );

endinterface

// File: rtl/aes_256_out_fifo.sv
// Ciphertext output buffer: power-of-two depth, count output,
// write and read in the same cycle allowed at any occupancy.
module aes_256_out_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 128
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign do_rd = rd_en && (count != '0);
  // a full buffer still accepts a write when the head leaves this cycle
  assign do_wr = wr_en && ((count != FULL) || do_rd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/aes_256_stream_ctrl.sv
// Feeds an external pipelined AES-256 core from a block stream,
// tracks blocks in flight and buffers ciphertext with credit control.
module aes_256_stream_ctrl
  import aes_256_stream_ctrl_pkg::*;
#(
  parameter int LATENCY    = DEF_LATENCY,
  parameter int KEY_SETTLE = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  aes_256_stream_ctrl_if.slave strm,
  output logic [BLOCK_W-1:0]   core_state,
  output logic [KEY_W-1:0]     core_key,
  input  logic [BLOCK_W-1:0]   core_out
);

  localparam int CW = (KEY_SETTLE > 1) ? $clog2(KEY_SETTLE) : 1;
  localparam int IW = $clog2(LATENCY + 1);
  localparam int FW = $clog2(FIFO_DEPTH) + 1;

  ctrl_state_t        state;
  logic [KEY_W-1:0]   key_q;
  logic [CW-1:0]      settle_cnt;
  logic [LATENCY-1:0] vld_sr;
  logic [IW-1:0]      inflight;
  logic [FW-1:0]      fifo_count;
  logic               credit_ok;
  logic               accept;
  logic               shift_out;
  logic               key_load;

  // every slot, in flight or buffered, must have room waiting in the FIFO
  assign credit_ok = (int'(inflight) + int'(fifo_count)) < FIFO_DEPTH;

  always_comb begin
    strm.key_ready = 1'b0;
    strm.in_ready  = 1'b0;
    unique case (state)
      NOKEY:   strm.key_ready = 1'b1;
      RUN:     strm.in_ready  = !strm.key_valid && credit_ok;
      DRAIN:   strm.key_ready = (inflight == '0);
      default: ;
    endcase
  end

  assign accept     = strm.in_valid && strm.in_ready;
  assign key_load   = strm.key_valid && strm.key_ready;
  assign shift_out  = vld_sr[LATENCY-1];
  assign core_state = accept ? strm.in_data : '0;
  assign core_key   = key_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= NOKEY;
      key_q      <= '0;
      settle_cnt <= '0;
    end else begin
      unique case (state)
        NOKEY, DRAIN: begin
          if (key_load) begin
            key_q      <= strm.key_in;
            settle_cnt <= CW'(KEY_SETTLE - 1);
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == '0) state <= RUN;
          else settle_cnt <= settle_cnt - 1'b1;
        end
        RUN: begin
          if (strm.key_valid) state <= DRAIN;
        end
        default: state <= NOKEY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_sr   <= '0;
      inflight <= '0;
    end else begin
      vld_sr <= LATENCY'({vld_sr, accept});
      if (accept && !shift_out) inflight <= inflight + 1'b1;
      else if (!accept && shift_out) inflight <= inflight - 1'b1;
    end
  end

  aes_256_out_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BLOCK_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (shift_out),
    .wr_data (core_out),
    .rd_en   (strm.out_ready),
    .rd_data (strm.out_data),
    .count   (fifo_count)
  );

  assign strm.out_valid = (fifo_count != '0);

endmodule

// File: tb/tb_aes_256_stream_ctrl.sv
// Directed bench for aes_256_stream_ctrl with a behavioural core model,
// plus a standalone check of the output FIFO.
module tb_aes_256_stream_ctrl;
  import aes_256_stream_ctrl_pkg::*;

  localparam int L = 15;
  localparam int S = 15;
  localparam logic [255:0] K0 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] K1 =
    256'hfeedc0de0badf00d1122334455667788a5a5a5a55a5a5a5a0123456789abcdef;
  localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C0 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_256_stream_ctrl_if ifa ();
  aes_256_stream_ctrl_if ifb ();

  logic [127:0] cs_a, co_a, cs_b, co_b;
  logic [255:0] ck_a, ck_b;

  aes_256_stream_ctrl #(
    .LATENCY (L), .KEY_SETTLE (S), .FIFO_DEPTH (32)
  ) dut (
    .clk (clk), .rst (rst), .strm (ifa),
    .core_state (cs_a), .core_key (ck_a), .core_out (co_a)
  );

  aes_256_stream_ctrl #(
    .LATENCY (L), .KEY_SETTLE (S), .FIFO_DEPTH (4)
  ) dut4 (
    .clk (clk), .rst (rst), .strm (ifb),
    .core_state (cs_b), .core_key (ck_b), .core_out (co_b)
  );

  logic       f_wr, f_rd;
  logic [7:0] f_wd, f_q;
  logic [2:0] f_cnt;

  aes_256_out_fifo #(.DEPTH (4), .WIDTH (8)) u_f (
    .clk (clk), .rst (rst), .wr_en (f_wr), .wr_data (f_wd),
    .rd_en (f_rd), .rd_data (f_q), .count (f_cnt)
  );

  // core stand-in: the known-answer vector, otherwise a keyed mix
  function automatic logic [127:0] core_f(input logic [127:0] s,
                                          input logic [255:0] k);
    if (k == K0 && s == P0) return C0;
    return s ^ k[255:128] ^ k[127:0] ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  endfunction

  logic [127:0] pipe_a [L];
  always @(posedge clk) begin
    pipe_a[0] <= core_f(cs_a, ck_a);
    for (int i = 1; i < L; i++) pipe_a[i] <= pipe_a[i-1];
  end
  assign co_a = pipe_a[L-1];
  assign co_b = cs_b ^ ck_b[127:0] ^ ck_b[255:128];

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [127:0] exp_q [$];
  int           pop_q [$];
  logic [255:0] cur_key = '0;
  int           acc_cyc = 0;
  int           key_cyc = 0;

  always begin
    @(negedge clk);
    #2;
    if (!rst && ifa.out_valid && ifa.out_ready) begin
      logic [127:0] e;
      pop_q.push_back(cyc);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      chk("out_data", ifa.out_data, e);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [127:0] d);
    ifa.in_valid = 1'b1;
    ifa.in_data  = d;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (ifa.in_ready) begin
        chk("core_state", cs_a, d);
        acc_cyc = cyc;
        exp_q.push_back(core_f(d, cur_key));
        @(negedge clk);
        ifa.in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    chk("send_timeout", ifa.in_ready, 1);
    ifa.in_valid = 1'b0;
  endtask

  task automatic load_key(input logic [255:0] k);
    ifa.key_valid = 1'b1;
    ifa.key_in    = k;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (ifa.key_ready) begin
        key_cyc = cyc;
        cur_key = k;
        @(negedge clk);
        ifa.key_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    chk("key_timeout", ifa.key_ready, 1);
    ifa.key_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int a0, c, bad, acc;
    rst = 1'b1;
    ifa.key_valid = 0; ifa.key_in = '0; ifa.in_valid = 0;
    ifa.in_data = '0; ifa.out_ready = 0;
    ifb.key_valid = 0; ifb.key_in = '0; ifb.in_valid = 0;
    ifb.in_data = '0; ifb.out_ready = 0;
    f_wr = 0; f_rd = 0; f_wd = '0;
    idle(3);
    #1;
    chk("rst_key_ready", ifa.key_ready, 1);
    chk("rst_in_ready", ifa.in_ready, 0);
    chk("rst_out_valid", ifa.out_valid, 0);
    chk("rst_out_data", ifa.out_data, 0);
    chk("rst_core_key", ck_a, 0);
    chk("rst_core_state", cs_a, 0);
    @(negedge clk);
    rst = 1'b0;

    // known-answer block, settle time and minimum latency
    load_key(K0);
    chk("core_key", ck_a, K0);
    send(P0);
    chk("settle", acc_cyc - key_cyc, S + 1);
    c = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ifa.out_valid) begin
        c = cyc;
        break;
      end
    end
    chk("latency", c - acc_cyc, L + 1);
    chk("kat_data", ifa.out_data, C0);
    ifa.out_ready = 1'b1;
    idle(2);

    // 20 back-to-back blocks
    pop_q.delete();
    send(128'h1000);
    a0 = acc_cyc;
    for (int i = 1; i < 20; i++) send(128'h1000 + 128'(i));
    chk("b2b_accept", acc_cyc - a0, 19);
    idle(40);
    chk("b2b_count", pop_q.size(), 20);
    bad = 0;
    foreach (pop_q[i]) if (pop_q[i] != pop_q[0] + i) bad++;
    chk("b2b_consec", bad, 0);
    chk("b2b_drained", exp_q.size(), 0);

    // rekey with 3 blocks in flight
    pop_q.delete();
    for (int i = 0; i < 3; i++) send(128'h2000 + 128'(i));
    a0 = acc_cyc;
    ifa.in_valid = 1'b1; ifa.in_data = 128'h2fff;
    ifa.key_valid = 1'b1; ifa.key_in = K1;
    #1;
    chk("in_ready_kv", ifa.in_ready, 0);
    ifa.in_valid = 1'b0;
    load_key(K1);
    chk("key_ready_delay", key_cyc - a0, L + 1);
    chk("old_key_outs", pop_q.size(), 3);
    send(128'h3000);
    chk("settle2", acc_cyc - key_cyc, S + 1);
    idle(L + 5);
    chk("rekey_count", pop_q.size(), 4);
    chk("rekey_drained", exp_q.size(), 0);

    // reset with 2 buffered and 5 in flight
    ifa.out_ready = 1'b0;
    send(128'h4000);
    send(128'h4001);
    idle(L + 4);
    chk("pre_rst_valid", ifa.out_valid, 1);
    for (int i = 0; i < 5; i++) send(128'h5000 + 128'(i));
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", ifa.out_valid, 0);
    chk("rst_mid_data", ifa.out_data, 0);
    chk("rst_mid_in_ready", ifa.in_ready, 0);
    chk("rst_mid_key_ready", ifa.key_ready, 1);
    exp_q.delete();
    cur_key = '0;
    idle(2);
    rst = 1'b0;
    ifa.out_ready = 1'b1;
    pop_q.delete();
    idle(40);
    chk("post_rst_outs", pop_q.size(), 0);

    // FIFO write+read at count 3 and at count 0
    for (int i = 0; i < 3; i++) begin
      f_wr = 1'b1; f_wd = 8'ha0 + 8'(i);
      @(negedge clk);
    end
    f_wr = 1'b0;
    chk("f_cnt3", f_cnt, 3);
    f_wr = 1'b1; f_rd = 1'b1; f_wd = 8'ha3;
    #1;
    chk("f_head", f_q, 8'ha0);
    @(negedge clk);
    f_wr = 1'b0; f_rd = 1'b0;
    chk("f_cnt_wr_rd_3", f_cnt, 3);
    f_rd = 1'b1;
    for (int i = 1; i < 4; i++) begin
      #1;
      chk("f_order", f_q, 8'ha0 + 8'(i));
      @(negedge clk);
    end
    f_rd = 1'b0;
    chk("f_cnt_empty", f_cnt, 0);
    f_wr = 1'b1; f_rd = 1'b1; f_wd = 8'hb5;
    @(negedge clk);
    f_wr = 1'b0; f_rd = 1'b0;
    chk("f_cnt_wr_rd_0", f_cnt, 1);
    chk("f_data_0", f_q, 8'hb5);

    // credit limit on the 4-deep instance
    ifb.key_valid = 1'b1; ifb.key_in = K1;
    @(negedge clk);
    ifb.key_valid = 1'b0;
    idle(S + 3);
    ifb.in_valid = 1'b1; ifb.in_data = 128'h6000;
    acc = 0;
    repeat (40) begin
      #1;
      if (ifb.in_valid && ifb.in_ready) acc++;
      @(negedge clk);
    end
    chk("credit_accepts", acc, 4);
    #1;
    chk("credit_in_ready", ifb.in_ready, 0);
    chk("credit_full", ifb.out_valid, 1);
    ifb.out_ready = 1'b1;
    @(negedge clk);
    ifb.out_ready = 1'b0;
    acc = 0;
    repeat (40) begin
      #1;
      if (ifb.in_valid && ifb.in_ready) acc++;
      @(negedge clk);
    end
    chk("credit_one_more", acc, 1);
    ifb.in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
